// File: rtl/ssd_scan_pkg.sv
// Shared types and constants for the multiplexed 14-segment display scanner.
// Optional PWM dimming is enabled by defining SSD_SCAN_DIM_EN.
package ssd_scan_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SEG_W      = 15;
    localparam int unsigned CNT_W      = 16;

    localparam logic [SEG_W-1:0]      SEG_OFF = '1;
    localparam logic [NUM_DIGITS-1:0] CTL_OFF = '1;

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } scan_state_e;

    function automatic logic [NUM_DIGITS-1:0] digit_sel(input logic [1:0] idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/ssd_pattern_regs.sv
// Shadow/active segment pattern registers; a pending commit copies shadow to
// active on the frame boundary so a frame never shows a mixed pattern set.
module ssd_pattern_regs
    import ssd_scan_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic [1:0]                        wr_addr,
    input  logic [SEG_W-1:0]                  wr_data,
    input  logic                              commit,
    input  logic                              frame,
    output logic                              commit_pend,
    output logic [NUM_DIGITS-1:0][SEG_W-1:0]  active
);

    logic [NUM_DIGITS-1:0][SEG_W-1:0] shadow;

    // Non-blocking copy takes the pre-write shadow when a write coincides.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow      <= '0;
            active      <= '0;
            commit_pend <= 1'b0;
        end else begin
            if (wr_en) begin
                shadow[wr_addr] <= wr_data;
            end
            if (frame && (commit_pend || commit)) begin
                active      <= shadow;
                commit_pend <= 1'b0;
            end else if (commit) begin
                commit_pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// 4-digit multiplexed segment display scanner with blanking dead time.
// Define SSD_SCAN_DIM_EN to compile in 8-step PWM dimming via bright.
module ssd_scan_ctrl
    import ssd_scan_pkg::*;
#(
    parameter int unsigned DWELL_CYC = 40000,
    parameter int unsigned BLANK_CYC = 400
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  wr_en,
    input  logic [1:0]            wr_addr,
    input  logic [SEG_W-1:0]      wr_data,
    input  logic                  commit,
    input  logic [NUM_DIGITS-1:0] dig_en,
    input  logic [2:0]            bright,
    output logic [SEG_W-1:0]      ssd_out,
    output logic [NUM_DIGITS-1:0] ssd_ctl,
    output logic                  frame_tick,
    output logic                  commit_pend
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    scan_state_e                      state, state_nxt;
    logic [CNT_W-1:0]                 cnt, cnt_nxt;
    logic [1:0]                       idx, idx_nxt;
    logic                             boundary;
    logic                             lit;
    logic [NUM_DIGITS-1:0][SEG_W-1:0] active;

    ssd_pattern_regs u_regs (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .commit      (commit),
        .frame       (boundary),
        .commit_pend (commit_pend),
        .active      (active)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_BLANK;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        idx_nxt   = idx;
        boundary  = 1'b0;
        if (!en) begin
            state_nxt = ST_BLANK;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                ST_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_nxt = ST_DRIVE;
                        cnt_nxt   = '0;
                    end
                end
                ST_DRIVE: begin
                    if (cnt == DWELL_LAST) begin
                        state_nxt = ST_BLANK;
                        cnt_nxt   = '0;
                        idx_nxt   = idx + 2'd1;
                        boundary  = (idx == 2'd3);
                    end
                end
                default: begin
                    state_nxt = ST_BLANK;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

`ifdef SSD_SCAN_DIM_EN
    logic [2:0] phase;

    // Phase restarts at 0 on every DRIVE entry because BLANK clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
        end else if (en && state == ST_DRIVE) begin
            phase <= phase + 3'd1;
        end else begin
            phase <= '0;
        end
    end

    assign lit = (phase <= bright);
`else
    logic unused_bright;
    assign unused_bright = ^bright;
    assign lit           = 1'b1;
`endif

    // Outputs are registered from the current state, so they trail it by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ssd_out    <= SEG_OFF;
            ssd_ctl    <= CTL_OFF;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= boundary;
            if (en && state == ST_DRIVE) begin
                ssd_out <= ~active[idx];
                ssd_ctl <= (dig_en[idx] && lit) ? digit_sel(idx) : CTL_OFF;
            end else begin
                ssd_out <= SEG_OFF;
                ssd_ctl <= CTL_OFF;
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Self-checking bench for ssd_scan_ctrl using a slot-arithmetic reference model.
module tb_ssd_scan_ctrl;

    localparam int D = 8;
    localparam int B = 2;
    localparam int S = B + D;
    localparam int P = 4 * S;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [14:0] wr_data;
    logic        commit;
    logic [3:0]  dig_en;
    logic [2:0]  bright;
    logic [14:0] ssd_out;
    logic [3:0]  ssd_ctl;
    logic        frame_tick;
    logic        commit_pend;

    int checks = 0;
    int errors = 0;

    // Model: n = enabled edges since scanning (re)started.
    int          n;
    logic [14:0] m_shadow [4];
    logic [14:0] m_active [4];
    logic        m_pend;

    ssd_scan_ctrl #(.DWELL_CYC(D), .BLANK_CYC(B)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .commit      (commit),
        .dig_en      (dig_en),
        .bright      (bright),
        .ssd_out     (ssd_out),
        .ssd_ctl     (ssd_ctl),
        .frame_tick  (frame_tick),
        .commit_pend (commit_pend)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        n      = 0;
        m_pend = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
    endtask

    // One clock: predict from pre-edge model, clock, compare, advance model.
    task automatic cyc();
        logic [3:0]  e_ctl;
        logic [14:0] e_out;
        logic        e_tick, lit, bnd;
        int          nn, pos, d, w;
        e_ctl  = 4'hF;
        e_out  = 15'h7FFF;
        e_tick = 1'b0;
        nn     = n + 1;
        if (en) begin
            pos = (nn - 1) % P;
            d   = pos / S;
            w   = pos % S;
            if (w >= B) begin
`ifdef SSD_SCAN_DIM_EN
                lit = (((w - B) % 8) <= int'(bright));
`else
                lit = 1'b1;
`endif
                e_out = ~m_active[d];
                if (dig_en[d] && lit) e_ctl = ~(4'b0001 << d);
            end
            e_tick = ((nn % P) == 0);
        end
        bnd = e_tick;
        if (bnd && (m_pend || commit)) begin
            for (int i = 0; i < 4; i++) m_active[i] = m_shadow[i];
            m_pend = 1'b0;
        end else if (commit) begin
            m_pend = 1'b1;
        end
        if (wr_en) m_shadow[wr_addr] = wr_data;
        n = en ? nn : 0;
        @(posedge clk);
        #1;
        chk("ssd_ctl", 15'(ssd_ctl), 15'(e_ctl));
        chk("ssd_out", ssd_out, e_out);
        chk("frame_tick", 15'(frame_tick), 15'(e_tick));
        chk("commit_pend", 15'(commit_pend), 15'(m_pend));
    endtask

    function automatic bit in_drive(input int nv, input int d);
        int pos;
        pos = (nv - 1) % P;
        return nv > 0 && (pos / S) == d && (pos % S) >= B + 2;
    endfunction

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) cyc();
    endtask

    task automatic run_to_boundary();
        for (int i = 0; i < P && ((n + 1) % P) != 0; i++) cyc();
    endtask

    task automatic run_to_drive(input int d);
        for (int i = 0; i < 2 * P && !in_drive(n, d); i++) cyc();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        commit = 1'b0; dig_en = 4'hF; bright = 3'd7;
        model_reset();
        #3;
        chk("rst_ctl", 15'(ssd_ctl), 15'hF);
        chk("rst_out", ssd_out, 15'h7FFF);
        chk("rst_tick", 15'(frame_tick), 15'h0);
        chk("rst_pend", 15'(commit_pend), 15'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        en  = 1'b1;

        // Basic scan: two frames plus a bit.
        run(2 * P + 5);

        // Write digit 1 and commit mid-frame.
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 15'h0001;
        cyc();
        wr_en = 1'b0; commit = 1'b1;
        cyc();
        commit = 1'b0;
        run(2 * P);
        run_to_drive(1);
        chk("dig1_pattern", ssd_out, 15'h7FFE);

        // Commit coincident with boundary while writing shadow[0].
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 15'h1234;
        cyc();
        wr_en = 1'b0; commit = 1'b1;
        cyc();
        commit = 1'b0;
        run(P + 3);
        run_to_boundary();
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 15'h0555; commit = 1'b1;
        cyc();
        wr_en = 1'b0; commit = 1'b0;
        run_to_drive(0);
        chk("old_shadow0", ssd_out, ~15'h1234);
        commit = 1'b1;
        cyc();
        commit = 1'b0;
        run(P + 2);
        run_to_drive(0);
        chk("new_shadow0", ssd_out, ~15'h0555);

        // Digit mask.
        dig_en = 4'b0101;
        run(P + 4);
        dig_en = 4'hF;

        // Drop en mid-drive of digit 2, then re-enable.
        run_to_drive(2);
        en = 1'b0;
        run(3);
        en = 1'b1;
        run(S + 6);

        // Dimming at bright=1 (full drive in the default build).
        bright = 3'd1;
        run(P);
        bright = 3'd7;

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            en      = ($urandom_range(0, 59) != 0);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 2'($urandom);
            wr_data = 15'($urandom);
            commit  = ($urandom_range(0, 24) == 0);
            if (i % 50 == 0) begin
                dig_en = 4'($urandom);
                bright = 3'($urandom);
            end
            cyc();
        end
        wr_en = 1'b0; commit = 1'b0; en = 1'b1; dig_en = 4'hF; bright = 3'd7;

        // Asynchronous reset while a digit is driven.
        run(P);
        run_to_drive(3);
        chk("pre_rst_ctl", 15'(ssd_ctl), 15'h7);
        rst = 1'b1;
        #1;
        chk("async_rst_ctl", 15'(ssd_ctl), 15'hF);
        chk("async_rst_out", ssd_out, 15'h7FFF);
        chk("async_rst_pend", 15'(commit_pend), 15'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        run(P + 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssd_scan_ctrl.md
SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL_CYC, default 40000, clk cycles each digit is driven (1 ms at 40 MHz); legal range 2..65535.
REQ-002 SHALL have parameter BLANK_CYC, default 400, clk cycles of all-off dead time between digits; legal range 1..DWELL_CYC-1.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  system clock, 40 MHz.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 en  in  1  scan enable; low forces blanking.
REQ-007 wr_en  in  1  write strobe into shadow pattern registers.
REQ-008 wr_addr  in  2  digit index written.
REQ-009 wr_data  in  15  segment pattern, 14 segments plus dp, 1 means lit.
REQ-010 commit  in  1  one-cycle request to move shadow patterns to active set.
REQ-011 dig_en  in  4  per-digit display mask, 1 means shown.
REQ-012 bright  in  3  brightness level, 7 means full.
REQ-013 ssd_out  out  15  segment drive, active-low.
REQ-014 ssd_ctl  out  4  digit select, active-low, one-cold while driving.
REQ-015 frame_tick  out  1  one-cycle pulse per completed 4-digit frame.
REQ-016 commit_pend  out  1  high while a commit waits for a frame boundary.

Function
REQ-017 SHALL implement FSM states BLANK and DRIVE, 16-bit cycle counter, 2-bit digit index idx.
REQ-018 BLANK: ssd_ctl=4'b1111, ssd_out=15'h7FFF; after BLANK_CYC cycles go to DRIVE with counter cleared.
REQ-019 DRIVE: ssd_ctl bit idx low when dig_en[idx]=1, otherwise all high; ssd_out=~active[idx]; after DWELL_CYC cycles go to BLANK and advance idx, wrapping 3->0.
REQ-020 On the DRIVE->BLANK transition with idx=3, SHALL pulse frame_tick for exactly one cycle; this edge is the frame boundary.
REQ-021 wr_en SHALL write wr_data to shadow[wr_addr] at the next clk edge; active set is never written directly.
REQ-022 commit SHALL set commit_pend; at a frame boundary with commit_pend high, all four active registers SHALL load shadow and commit_pend SHALL clear.
REQ-023 Commit and frame boundary in the same cycle: copy occurs on that boundary.
REQ-024 A write in the copy cycle SHALL land in shadow only; the copy uses pre-write shadow contents.
REQ-025 en low SHALL synchronously force BLANK, idx=0, counter=0, and suppress frame_tick; shadow, active and commit_pend are held.
REQ-026 When en rises, scanning SHALL restart with a full BLANK_CYC interval before digit 0.
REQ-027 Outputs SHALL be registered; ssd_out and ssd_ctl change only on clk edges.

Reset
REQ-028 rst SHALL force, without waiting for clk: state=BLANK, idx=0, counter=0, shadow and active all 0, commit_pend=0, frame_tick=0, ssd_ctl=4'b1111, ssd_out=15'h7FFF.
REQ-029 rst asserted mid-DRIVE SHALL immediately deselect all digits.
REQ-030 After deassertion, first digit select SHALL occur BLANK_CYC+1 cycles later.

Configuration
REQ-031 Macro SSD_SCAN_DIM_EN SHALL compile in PWM dimming.
REQ-032 With SSD_SCAN_DIM_EN: a 3-bit phase counter free-runs in DRIVE; selected digit is asserted only while phase <= bright. bright=7 gives full on; bright=0 gives 1/8 duty.
REQ-033 Without SSD_SCAN_DIM_EN: bright is ignored and digits are driven for the whole DRIVE interval.

Structure
REQ-034 Package ssd_scan_pkg SHALL hold the state type, NUM_DIGITS=4, SEG_W=15, CNT_W=16, and the blank patterns SEG_OFF and CTL_OFF.
REQ-035 The shadow/active register pair with commit logic SHALL be sub-module ssd_pattern_regs; FSM, counter and PWM stay in the top.

Verification
REQ-036 DWELL_CYC=8, BLANK_CYC=2, rst released, en=1 -> ssd_ctl 1110,1101,1011,0111 each low 8 cycles with 2-cycle all-high gaps; frame_tick every 40 cycles.
REQ-037 Write shadow[1]=15'h0001, commit mid-frame -> commit_pend high until frame_tick; ssd_out=15'h7FFE only in digit-1 slots of the next frame.
REQ-038 commit in the same cycle as frame boundary, with wr_en to shadow[0] -> copy uses old shadow[0]; new value is visible only after a second commit.
REQ-039 dig_en=4'b0101 -> ssd_ctl stays 1111 in slots 1 and 3; timing unchanged.
REQ-040 en dropped mid-DRIVE of digit 2 -> next cycle ssd_ctl=1111; on re-enable, digit 0 is selected after 2 blank cycles.
REQ-041 With SSD_SCAN_DIM_EN, bright=1 -> digit selected 2 of every 8 DRIVE cycles; async rst mid-DRIVE -> ssd_ctl=1111 before the next clk edge.
